ns_quantizer: RTL and testbench

Parametrised noise-shaping multi-bit quantizer for the DEM-DAC datapath; successor to the fixed-width `quantizer`. It rounds an unsigned INPUT_WIDTH sample to OUTPUT_WIDTH bits with runtime-selectable error-feedback order (0, 1 or 2) and saturation with error clamping. Each result is emitted in binary and thermometer form, so the thermometer word can drive the DEM switch block directly. It sits between the digital modulator input and the DEM element selector.

---
 rtl/ns_quantizer_if.sv | 31 +++
 rtl/ns_quantizer.sv | 94 +++++++++
 tb/tb_ns_quantizer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ns_quantizer_if.sv
// Sample-in / result-out bus of the noise-shaping quantizer.
interface ns_quantizer_if #(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned OUTPUT_WIDTH = 3
);
  localparam int unsigned QMAX  = (1 << OUTPUT_WIDTH) - 1;
  localparam int unsigned ERR_W = INPUT_WIDTH - OUTPUT_WIDTH + 2;
  localparam int unsigned TH_W  = QMAX;

  logic                     valid_i;
  logic [INPUT_WIDTH-1:0]   x_in_i;
  logic [1:0]               mode_i;
  logic                     clear_i;
  logic                     valid_o;
  logic [OUTPUT_WIDTH-1:0]  quantized_out_o;
  logic [TH_W-1:0]          therm_o;
  logic signed [ERR_W-1:0]  quant_error_o;
  logic                     overload_o;

  // Sample source side.
  modport master (
    output valid_i, x_in_i, mode_i, clear_i,
    input  valid_o, quantized_out_o, therm_o, quant_error_o, overload_o
  );

  // Quantizer side.
  modport slave (
    input  valid_i, x_in_i, mode_i, clear_i,
    output valid_o, quantized_out_o, therm_o, quant_error_o, overload_o
  );
endinterface

// File: rtl/ns_quantizer.sv
// Noise-shaping multi-bit quantizer: error feedback of order 0/1/2, saturation
// with error clamping, binary and thermometer outputs, one cycle of latency.
module ns_quantizer #(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned OUTPUT_WIDTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ns_quantizer_if.slave      bus
);
  localparam int unsigned SH    = INPUT_WIDTH - OUTPUT_WIDTH;
  localparam int unsigned STEP  = 1 << SH;
  localparam int unsigned HALF  = STEP / 2;
  localparam int unsigned QMAX  = (1 << OUTPUT_WIDTH) - 1;
  localparam int unsigned ERR_W = SH + 2;
  localparam int unsigned TH_W  = QMAX;
  localparam int unsigned V_W   = INPUT_WIDTH + 2;

  localparam logic signed [V_W-1:0] HALF_V    = V_W'(HALF);
  localparam logic signed [V_W-1:0] QMAX_V    = V_W'(QMAX);
  localparam logic signed [V_W-1:0] ERR_MAX_V = V_W'(STEP - 1);
  localparam logic signed [V_W-1:0] ERR_MIN_V = -(V_W'(STEP));

  logic signed [ERR_W-1:0]  e1_q, e2_q;
  logic signed [ERR_W-1:0]  h1_c, h2_c;
  logic signed [V_W-1:0]    x_c, h1x_c, h2x_c, v_c, sum_c, qr_c, qstep_c, ef_c;
  logic [OUTPUT_WIDTH-1:0]  q_c;
  logic                     ovf_c;
  logic signed [ERR_W-1:0]  e_c;
  logic [TH_W-1:0]          th_c;

  // Shaped value, rounding, saturation, clamped error and thermometer code.
  always_comb begin
    h1_c    = bus.clear_i ? '0 : e1_q;
    h2_c    = bus.clear_i ? '0 : e2_q;
    x_c     = signed'({2'b00, bus.x_in_i});
    h1x_c   = V_W'(h1_c);
    h2x_c   = V_W'(h2_c);
    case (bus.mode_i)
      2'b00:   v_c = x_c;
      2'b01:   v_c = x_c + h1x_c;
      default: v_c = x_c + (h1x_c <<< 1) - h2x_c;
    endcase
    sum_c   = v_c + HALF_V;
    qr_c    = sum_c >>> SH;
    q_c     = qr_c[OUTPUT_WIDTH-1:0];
    ovf_c   = 1'b0;
    if (qr_c[V_W-1]) begin
      q_c   = '0;
      ovf_c = 1'b1;
    end else if (qr_c > QMAX_V) begin
      q_c   = OUTPUT_WIDTH'(QMAX);
      ovf_c = 1'b1;
    end
    qstep_c = signed'(V_W'(q_c)) <<< SH;
    ef_c    = v_c - qstep_c;
    if (ef_c > ERR_MAX_V) begin
      ef_c = ERR_MAX_V;
    end else if (ef_c < ERR_MIN_V) begin
      ef_c = ERR_MIN_V;
    end
    e_c     = ef_c[ERR_W-1:0];
    th_c    = '0;
    for (int k = 0; k < int'(TH_W); k++) begin
      th_c[k] = (OUTPUT_WIDTH'(k) < q_c);
    end
  end

  // Result registers and error history; outputs hold while no sample arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.valid_o         <= 1'b0;
      bus.quantized_out_o <= '0;
      bus.therm_o         <= '0;
      bus.quant_error_o   <= '0;
      bus.overload_o      <= 1'b0;
      e1_q                <= '0;
      e2_q                <= '0;
    end else begin
      bus.valid_o <= bus.valid_i;
      if (bus.valid_i) begin
        bus.quantized_out_o <= q_c;
        bus.therm_o         <= th_c;
        bus.quant_error_o   <= e_c;
        bus.overload_o      <= ovf_c;
        e1_q                <= e_c;
        e2_q                <= h1_c;
      end else if (bus.clear_i) begin
        e1_q <= '0;
        e2_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ns_quantizer.sv
// Testbench for ns_quantizer: fixed vectors, hand-written gap/clear/reset
// sequences and a randomized run, all checked through an expected-result queue.
module tb_ns_quantizer;
  localparam int STEP = 8192;
  localparam int HALF = 4096;
  localparam int QMAX = 7;

  typedef struct {
    int q;
    int e;
    bit ov;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic        clr;
    logic [15:0] x;
    int          q;
    int          e;
    bit          ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   me1 = 0;
  int   me2 = 0;

  ns_quantizer_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(3)) bus ();

  ns_quantizer #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer floor division, separate saturation and clamp.
  task automatic model(input logic [1:0] m, input logic c, input logic [15:0] x,
                       output exp_t r);
    int a1, a2, v, t, qr;
    a1 = c ? 0 : me1;
    a2 = c ? 0 : me2;
    if (m == 2'b00)      v = int'(x);
    else if (m == 2'b01) v = int'(x) + a1;
    else                 v = int'(x) + 2 * a1 - a2;
    t  = v + HALF;
    qr = (t >= 0) ? t / STEP : -((-t + STEP - 1) / STEP);
    r.q  = (qr < 0) ? 0 : (qr > QMAX) ? QMAX : qr;
    r.ov = (r.q != qr);
    r.e  = v - r.q * STEP;
    if (r.e > STEP - 1) r.e = STEP - 1;
    if (r.e < -STEP)    r.e = -STEP;
    me2 = a1;
    me1 = r.e;
  endtask

  // One cycle of stimulus, applied at the falling edge.
  task automatic drive(input logic v, input logic [1:0] m, input logic c,
                       input logic [15:0] x, input logic r,
                       input bit use_exp, input exp_t ex);
    exp_t mr;
    @(negedge clk);
    rst         = r;
    bus.valid_i = v;
    bus.mode_i  = m;
    bus.clear_i = c;
    bus.x_in_i  = x;
    if (r) begin
      me1 = 0;
      me2 = 0;
    end else if (v) begin
      model(m, c, x, mr);
      sb.push_back(use_exp ? ex : mr);
    end else if (c) begin
      me1 = 0;
      me2 = 0;
    end
  endtask

  task automatic idle(input logic r);
    exp_t z;
    z = '{0, 0, 1'b0};
    drive(1'b0, 2'b00, 1'b0, 16'd0, r, 1'b0, z);
  endtask

  task automatic chk_outputs(input string name, input bit vo, input int q,
                             input int e, input bit ov);
    chk({name, "_valid"}, bus.valid_o, vo);
    chk({name, "_q"}, bus.quantized_out_o, q);
    chk({name, "_therm"}, bus.therm_o, (1 << q) - 1);
    chk({name, "_err"}, longint'(bus.quant_error_o), e);
    chk({name, "_ovl"}, bus.overload_o, ov);
  endtask

  // Pops the expected result for every emitted sample.
  always @(negedge clk) begin
    exp_t ex;
    if (bus.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        ex = sb.pop_front();
        chk("q", bus.quantized_out_o, ex.q);
        chk("therm", bus.therm_o, (1 << ex.q) - 1);
        chk("err", longint'(bus.quant_error_o), ex.e);
        chk("ovl", bus.overload_o, ex.ov);
      end
    end
  end

  initial begin
    vec_t vecs[14];
    exp_t ex;
    int   wait_cyc;

    vecs[0]  = '{2'b00, 1'b1, 16'd12288, 2, -4096, 1'b0};
    vecs[1]  = '{2'b01, 1'b1, 16'd12288, 2, -4096, 1'b0};
    vecs[2]  = '{2'b01, 1'b0, 16'd12288, 1,     0, 1'b0};
    vecs[3]  = '{2'b01, 1'b0, 16'd12288, 2, -4096, 1'b0};
    vecs[4]  = '{2'b01, 1'b0, 16'd12288, 1,     0, 1'b0};
    vecs[5]  = '{2'b10, 1'b1, 16'd10240, 1,  2048, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, 16'd10240, 2, -2048, 1'b0};
    vecs[7]  = '{2'b10, 1'b0, 16'd10240, 1, -4096, 1'b0};
    vecs[8]  = '{2'b10, 1'b0, 16'd10240, 1, -4096, 1'b0};
    vecs[9]  = '{2'b11, 1'b1, 16'd10240, 1,  2048, 1'b0};
    vecs[10] = '{2'b11, 1'b0, 16'd10240, 2, -2048, 1'b0};
    vecs[11] = '{2'b00, 1'b0, 16'd65535, 7,  8191, 1'b1};
    vecs[12] = '{2'b00, 1'b0, 16'd0,     0,     0, 1'b0};
    vecs[13] = '{2'b01, 1'b1, 16'd4095,  0,  4095, 1'b0};

    rst         = 1'b1;
    bus.valid_i = 1'b1;
    bus.mode_i  = 2'b00;
    bus.clear_i = 1'b0;
    bus.x_in_i  = 16'd40000;

    // Reset held three cycles with a live sample on the input.
    ex = '{0, 0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 1'b0, 16'd40000, 1'b1, 1'b0, ex);
      if (i > 0) chk_outputs("reset", 1'b0, 0, 0, 1'b0);
    end
    idle(1'b0);
    chk_outputs("post_reset", 1'b0, 0, 0, 1'b0);
    idle(1'b0);
    chk_outputs("post_reset_idle", 1'b0, 0, 0, 1'b0);

    // Table vectors, back to back.
    foreach (vecs[i]) begin
      ex = '{vecs[i].q, vecs[i].e, vecs[i].ov};
      drive(1'b1, vecs[i].mode, vecs[i].clr, vecs[i].x, 1'b0, 1'b1, ex);
    end
    idle(1'b0);

    // Gaps keep history and outputs; clear restarts; reset drops the sample.
    ex = '{2, -4096, 1'b0};
    drive(1'b1, 2'b01, 1'b1, 16'd12288, 1'b0, 1'b1, ex);
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk_outputs("gap_hold", 1'b0, 2, -4096, 1'b0);
    end
    ex = '{1, 0, 1'b0};
    drive(1'b1, 2'b01, 1'b0, 16'd12288, 1'b0, 1'b1, ex);
    ex = '{2, -4096, 1'b0};
    drive(1'b1, 2'b01, 1'b1, 16'd12288, 1'b0, 1'b1, ex);
    drive(1'b1, 2'b01, 1'b0, 16'd12288, 1'b1, 1'b0, ex);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk_outputs("midstream_reset", 1'b0, 0, 0, 1'b0);
    end

    // Randomized run with gaps, clears, mode changes and extreme inputs.
    for (int i = 0; i < 400; i++) begin
      logic        rv, rc;
      logic [1:0]  rm;
      logic [15:0] rx;
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 15) == 0);
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       rx = 16'd0;
        1:       rx = 16'hFFFF;
        2:       rx = 16'($urandom_range(0, 2048));
        default: rx = 16'($urandom_range(0, 65535));
      endcase
      drive(rv, rm, rc, rx, 1'b0, 1'b0, ex);
    end

    // Drain outstanding results with a bounded wait.
    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 10) begin
      idle(1'b0);
      wait_cyc++;
    end
    chk("drain_pending", sb.size(), 0);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
